// File: rtl/frame_readout_pkg.sv
// frame_readout_pkg: shared state encodings and byte constants for the frame readout controller.
package frame_readout_pkg;
    typedef enum logic [3:0] {
        IDLE, ARG_HI, ARG_LO, ARM, WAIT_LINE, HDR_SYNC, HDR_HI, HDR_LO,
        PIX_ADDR, PIX_SEND, NEXT_LINE, TRAILER, ERR
    } state_t;
    typedef enum logic [1:0] {TX_RDY, TX_DROP, TX_RISE} tx_state_t;
    localparam logic [7:0] CMD_FRAME = 8'h46;
    localparam logic [7:0] CMD_LINE = 8'h4C;
    localparam logic [7:0] CMD_ABORT = 8'h58;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_END_BYTE = 8'h5A;
    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;
endpackage

// File: rtl/frame_readout_if.sv
// frame_readout_if: UART rx/tx, line buffer and status signals around the readout controller.
interface frame_readout_if #(parameter int H = 752, parameter int V = 480);
    localparam int AW = $clog2(H);
    localparam int LW = $clog2(V);
    logic [7:0] RX_DATA;
    logic RX_READY;
    logic [7:0] TX_DATA;
    logic TX_DATA_READY;
    logic TX_IDLE;
    logic LINE_READY;
    logic RESET_READY_FLAG;
    logic [LW-1:0] INTERESTING_LINE;
    logic [AW-1:0] READ_ADDRESS;
    logic [9:0] PIXEL_DATA;
    logic BUSY;
    modport master (
        input RX_DATA, RX_READY, TX_IDLE, LINE_READY, PIXEL_DATA,
        output TX_DATA, TX_DATA_READY, RESET_READY_FLAG, INTERESTING_LINE, READ_ADDRESS, BUSY
    );
    modport slave (
        output RX_DATA, RX_READY, TX_IDLE, LINE_READY, PIXEL_DATA,
        input TX_DATA, TX_DATA_READY, RESET_READY_FLAG, INTERESTING_LINE, READ_ADDRESS, BUSY
    );
endinterface

// File: rtl/frame_readout_ctrl_tx_byte_issuer.sv
// tx_byte_issuer: strobes one byte into uart_send, then waits for TX_IDLE to fall and rise again.
module tx_byte_issuer
    import frame_readout_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       i_tx_idle,
    output logic [7:0] o_tx_data,
    output logic       o_tx_strobe,
    output logic       o_done,
    output logic       o_idle
);
    tx_state_t r_state, w_next;
    logic w_issue;
    always_comb begin
        w_issue = r_state == TX_RDY && i_req && i_tx_idle;
        w_next = w_issue ? TX_DROP :
                 (r_state == TX_DROP && !i_tx_idle) ? TX_RISE :
                 (r_state == TX_RISE && i_tx_idle) ? TX_RDY : r_state;
        o_done = r_state == TX_RISE && i_tx_idle;
        o_idle = r_state == TX_RDY;
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= TX_RDY;
            o_tx_data <= 8'h00;
            o_tx_strobe <= 1'b0;
        end else begin
            r_state <= w_next;
            o_tx_strobe <= w_issue;
            if (w_issue) o_tx_data <= i_byte;
        end
    end
endmodule

// File: rtl/frame_readout_ctrl.sv
// frame_readout_ctrl: command-driven readout of line_buffer lines to uart_send with per-line headers and a trailer.
module frame_readout_ctrl
    import frame_readout_pkg::*;
#(
    parameter int H = 752,
    parameter int V = 480,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter logic [7:0] END_BYTE = DEF_END_BYTE,
    parameter logic [7:0] ERR_BYTE = DEF_ERR_BYTE
) (
    input logic CLK,
    input logic RST,
    frame_readout_if.master bus
);
    localparam int AW = $clog2(H);
    localparam int LW = $clog2(V);
    localparam logic [AW-1:0] ADDR_LAST = AW'(H - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V - 1);
    localparam logic [15:0] LINE_LIMIT = 16'(V);
    state_t r_state, w_next;
    logic r_rx_q, r_full, r_abort;
    logic [7:0] r_arg_hi;
    logic [LW-1:0] r_line;
    logic [AW-1:0] r_addr;
    logic w_byte_rx, w_abortable, w_send, w_req, w_stop, w_done, w_iss_idle;
    logic w_arg_ok, w_last_pix, w_more;
    logic [7:0] w_byte;
    logic [15:0] w_arg16, w_idx16;
    always_comb begin
        w_byte_rx = bus.RX_READY & ~r_rx_q;
        w_arg16 = {r_arg_hi, bus.RX_DATA};
        w_arg_ok = w_arg16 < LINE_LIMIT;
        w_idx16 = 16'(r_line);
        w_last_pix = r_addr == ADDR_LAST;
        w_more = r_line < LINE_LAST;
        w_abortable = r_state inside {ARM, WAIT_LINE, HDR_SYNC, HDR_HI, HDR_LO, PIX_ADDR, PIX_SEND};
        w_send = r_state inside {HDR_SYNC, HDR_HI, HDR_LO, PIX_SEND, TRAILER, ERR};
        // a pending abort blocks new strobes; the trailer waits until the in-flight byte is done
        w_req = w_send && !(r_abort && w_abortable);
        w_stop = r_abort && w_abortable && w_iss_idle;
        w_byte = r_state == HDR_SYNC ? SYNC_BYTE :
                 r_state == HDR_HI ? w_idx16[15:8] :
                 r_state == HDR_LO ? w_idx16[7:0] :
                 r_state == PIX_SEND ? 8'(bus.PIXEL_DATA >> 2) :
                 r_state == TRAILER ? END_BYTE : ERR_BYTE;
    end
    always_comb begin
        w_next = r_state;
        if (w_stop) w_next = TRAILER;
        else case (r_state)
            IDLE: w_next = !w_byte_rx ? IDLE :
                           bus.RX_DATA == CMD_FRAME ? ARM :
                           bus.RX_DATA == CMD_LINE ? ARG_HI : IDLE;
            ARG_HI: if (w_byte_rx) w_next = bus.RX_DATA == CMD_ABORT ? IDLE : ARG_LO;
            ARG_LO: if (w_byte_rx) w_next = bus.RX_DATA == CMD_ABORT ? IDLE : w_arg_ok ? ARM : ERR;
            ARM: w_next = WAIT_LINE;
            WAIT_LINE: if (bus.LINE_READY) w_next = HDR_SYNC;
            HDR_SYNC: if (w_done) w_next = HDR_HI;
            HDR_HI: if (w_done) w_next = HDR_LO;
            HDR_LO: if (w_done) w_next = PIX_ADDR;
            PIX_ADDR: w_next = PIX_SEND;
            PIX_SEND: if (w_done) w_next = w_last_pix ? NEXT_LINE : PIX_ADDR;
            NEXT_LINE: w_next = (r_full && w_more) ? ARM : TRAILER;
            TRAILER, ERR: if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_rx_q <= 1'b0;
            r_full <= 1'b0;
            r_abort <= 1'b0;
            r_arg_hi <= 8'h00;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            r_state <= w_next;
            r_rx_q <= bus.RX_READY;
            if (r_state == IDLE) r_abort <= 1'b0;
            else if (w_byte_rx && bus.RX_DATA == CMD_ABORT && w_abortable) r_abort <= 1'b1;
            if (r_state == IDLE && w_byte_rx && bus.RX_DATA == CMD_FRAME) begin
                r_full <= 1'b1;
                r_line <= '0;
            end
            if (r_state == IDLE && w_byte_rx && bus.RX_DATA == CMD_LINE) r_full <= 1'b0;
            if (r_state == ARG_HI && w_byte_rx) r_arg_hi <= bus.RX_DATA;
            if (r_state == ARG_LO && w_byte_rx && bus.RX_DATA != CMD_ABORT && w_arg_ok) r_line <= w_arg16[LW-1:0];
            if (r_state == PIX_SEND && w_done && !w_last_pix) r_addr <= r_addr + 1'b1;
            if (r_state == NEXT_LINE || r_state == IDLE) r_addr <= '0;
            if (r_state == NEXT_LINE && r_full && w_more) r_line <= r_line + 1'b1;
        end
    end
    assign bus.BUSY = r_state != IDLE;
    assign bus.RESET_READY_FLAG = r_state == IDLE || r_state == ARM;
    assign bus.INTERESTING_LINE = r_line;
    assign bus.READ_ADDRESS = r_addr;
    tx_byte_issuer u_tx (
        .CLK(CLK),
        .RST(RST),
        .i_req(w_req),
        .i_byte(w_byte),
        .i_tx_idle(bus.TX_IDLE),
        .o_tx_data(bus.TX_DATA),
        .o_tx_strobe(bus.TX_DATA_READY),
        .o_done(w_done),
        .o_idle(w_iss_idle)
    );
endmodule

// File: tb/tb_frame_readout_ctrl.sv
// tb_frame_readout_ctrl: directed commands with a byte scoreboard against uart_send and line_buffer models (H=4, V=3).
module tb_frame_readout_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    frame_readout_if #(.H(4), .V(3)) bus ();
    frame_readout_ctrl #(.H(4), .V(3)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0, cyc = 0, arm_cnt = 0, arm_cyc = 0, stb_cnt = 0;
    logic [7:0] exp_q[$];
    logic sb_en = 1'b1, gap_chk = 1'b0, stale_en = 1'b0, tx_hold = 1'b0, prev_stb = 1'b0;
    logic [2:0] tx_cnt = 3'd0, lr_cnt = 3'd0;
    logic lr_flag = 1'b0, arm_seen = 1'b0;

    // uart_send: idle drops 2 cycles after the strobe and recovers a few cycles later
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        tx_cnt <= bus.TX_DATA_READY ? 3'd1 : (tx_cnt == 3'd0 || tx_cnt == 3'd6) ? 3'd0 : tx_cnt + 3'd1;
    end
    assign bus.TX_IDLE = !tx_hold && !(tx_cnt >= 3'd2);

    // line_buffer: flag clears while RESET_READY_FLAG is high, sets 5 cycles after it falls
    always @(posedge CLK) begin
        bus.PIXEL_DATA <= {4'h0, bus.READ_ADDRESS, bus.INTERESTING_LINE, 2'b11};
        if (bus.RESET_READY_FLAG) begin
            lr_flag <= 1'b0;
            lr_cnt <= 3'd0;
        end else if (!lr_flag) begin
            lr_cnt <= lr_cnt + 3'd1;
            if (lr_cnt == 3'd4) lr_flag <= 1'b1;
        end
        arm_seen <= !bus.BUSY ? 1'b0 : bus.RESET_READY_FLAG ? 1'b1 : arm_seen;
    end
    assign bus.LINE_READY = lr_flag | (stale_en & ~arm_seen);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (bus.RESET_READY_FLAG && bus.BUSY) begin
            arm_cnt++;
            arm_cyc = cyc;
        end
        if (bus.TX_DATA_READY) begin
            stb_cnt++;
            if (prev_stb) begin
                n_chk++;
                $display("FAIL tx_back_to_back: got strobe on consecutive cycles expected single-cycle strobe");
            end
            if (gap_chk) begin
                chk("arm_to_header_gap_ok", 32'(cyc - arm_cyc >= 6), 32'd1);
                gap_chk = 1'b0;
            end
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL tx_extra: got %02h expected no byte", bus.TX_DATA);
                end else chk("tx_byte", 32'(bus.TX_DATA), 32'(exp_q.pop_front()));
            end
        end
        prev_stb = bus.TX_DATA_READY;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_DATA = b;
        bus.RX_READY = 1'b1;
        repeat (2) @(negedge CLK);
        bus.RX_READY = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic push_line(input int l);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(l));
        for (int a = 0; a < 4; a++) exp_q.push_back(8'(a * 4 + l));
    endtask

    task automatic push_frame();
        for (int l = 0; l < 3; l++) push_line(l);
        exp_q.push_back(8'h5A);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || bus.BUSY) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_busy_low"}, 32'(bus.BUSY), 32'd0);
    endtask

    task automatic wait_byte(input string nm, input logic [7:0] b);
        int n = 0;
        while (!(bus.TX_DATA_READY && bus.TX_DATA == b) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, "_seen"}, 32'(bus.TX_DATA_READY && bus.TX_DATA == b), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.RX_DATA = 8'h00;
        bus.RX_READY = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_tx_ready", 32'(bus.TX_DATA_READY), 32'd0);
        chk("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        chk("rst_rrf", 32'(bus.RESET_READY_FLAG), 32'd1);
        chk("rst_line", 32'(bus.INTERESTING_LINE), 32'd0);
        chk("rst_addr", 32'(bus.READ_ADDRESS), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        arm_cnt = 0;
        push_frame();
        send_byte(8'h46);
        wait_done("full");
        chk("full_arm_pulses", 32'(arm_cnt), 32'd3);

        arm_cnt = 0;
        push_line(1);
        exp_q.push_back(8'h5A);
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_done("line1");
        chk("line1_interesting_line", 32'(bus.INTERESTING_LINE), 32'd1);
        chk("line1_arm_pulses", 32'(arm_cnt), 32'd1);

        arm_cnt = 0;
        exp_q.push_back(8'hEE);
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h03);
        wait_done("bad_line");
        chk("bad_line_arm_pulses", 32'(arm_cnt), 32'd0);

        push_line(0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h5A);
        send_byte(8'h46);
        wait_byte("abort_pixel2", 8'h09);
        send_byte(8'h58);
        wait_done("abort");
        chk("abort_rrf_idle", 32'(bus.RESET_READY_FLAG), 32'd1);

        stale_en = 1'b1;
        repeat (10) @(negedge CLK);
        gap_chk = 1'b1;
        push_frame();
        s = stb_cnt;
        send_byte(8'h46);
        for (int n = 0; n < 2000 && stb_cnt < s + 3; n++) @(negedge CLK);
        chk("stale_three_bytes_out", 32'(stb_cnt >= s + 3), 32'd1);
        tx_hold = 1'b1;
        @(negedge CLK);
        s = stb_cnt;
        repeat (50) @(negedge CLK);
        chk("hold_no_strobe", 32'(stb_cnt - s), 32'd0);
        tx_hold = 1'b0;
        wait_done("stale");
        chk("stale_gap_checked", 32'(gap_chk), 32'd0);
        stale_en = 1'b0;

        sb_en = 1'b0;
        send_byte(8'h46);
        wait_byte("reset_pixel1", 8'h04);
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_tx_ready", 32'(bus.TX_DATA_READY), 32'd0);
        chk("midrst_busy", 32'(bus.BUSY), 32'd0);
        chk("midrst_addr", 32'(bus.READ_ADDRESS), 32'd0);
        chk("midrst_rrf", 32'(bus.RESET_READY_FLAG), 32'd1);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        sb_en = 1'b1;
        arm_cnt = 0;
        push_frame();
        send_byte(8'h46);
        wait_done("after_reset");
        chk("after_reset_arm_pulses", 32'(arm_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
